mem_req_arbiter: RTL and testbench
==================================

Name: mem_req_arbiter

Overview:
- Upstream arbitration stage for the shared memory-request path.
- Chooses one of REQUESTERS valid/ready requesters and drives the select index consumed by the downstream priority data mux.
- Locks the grant until the downstream port accepts the request and signals transaction completion.
- Fixed priority, index 0 highest; a per-requester wait counter promotes starved requesters.

Parameters:
- REQUESTERS, 2, number of requesters; must be >= 2.
- MAX_WAIT, 8, number of lost arbitration decisions after which a requester becomes urgent; must be >= 1.
- SEL_WIDTH, $clog2(REQUESTERS), width of the select index (derived, not overridable).

Ports:
- clk_in  input  1  clock; all state updates on rising edge.
- rst_in  input  1  reset, synchronous, active-high.
- req_valid_in  input  REQUESTERS  per-requester request valid.
- req_ready_out  output  REQUESTERS  per-requester accept; one-hot or zero.
- select_out  output  SEL_WIDTH  index of the granted requester; drives the downstream mux select.
- grant_valid_out  output  1  a granted request is presented downstream.
- down_ready_in  input  1  downstream accepts the presented request.
- txn_done_in  input  1  downstream transaction for the accepted request is complete.
- busy_out  output  1  the arbiter is locked on an accepted transaction.

Behaviour:
- Reset: rst_in high at a clock edge gives:
  - state IDLE;
  - select_out = 0, grant_valid_out = 0, busy_out = 0, req_ready_out = 0;
  - all wait counters = 0.
  - Reset overrides any in-flight state; the transaction is abandoned, no completion is expected.
- State IDLE:
  - If any req_valid_in bit is set, perform an arbitration decision.
  - Winner is the lowest-index urgent requester (wait counter == MAX_WAIT) if any; otherwise the lowest-index valid requester.
  - Register winner into select_out and go to GRANTED.
  - Latency: request-to-grant_valid_out is 1 cycle.
  - No valid requests: stay IDLE, hold select_out.
- State GRANTED:
  - grant_valid_out = 1.
  - req_ready_out[select_out] = down_ready_in; all other bits = 0 (combinational from down_ready_in).
  - Handshake: req_valid_in[select_out] && down_ready_in means accepted; go to BUSY.
  - req_valid_in[select_out] dropped before acceptance (protocol violation): return to IDLE, no transfer, counters unchanged.
- State BUSY:
  - busy_out = 1, grant_valid_out = 0, req_ready_out = 0, select_out held stable.
  - txn_done_in high: go to IDLE. The next grant comes no earlier than 2 cycles after done (1 bubble).
- txn_done_in is ignored outside BUSY.
- Wait counters update only on the arbitration-decision cycle:
  - winner's counter cleared to 0;
  - each other valid requester's counter increments, saturating at MAX_WAIT;
  - counters of requesters with valid low are cleared.
- Counter width is $clog2(MAX_WAIT+1). Saturation, not wrap, is required.
- select_out never changes outside IDLE-decision cycles, so the downstream mux output is stable for the whole transaction.
- Outputs grant_valid_out, busy_out and select_out are registered (state-decoded); req_ready_out is the only combinational output.

Decomposition:
- Shared package mem_arb_pkg:
  - arb_state_e enum: IDLE, GRANTED, BUSY.
  - Default REQUESTERS / MAX_WAIT constants.
  - Function for the lowest-set-bit index.
- One natural sub-module: arb_pick, a combinational priority encoder taking valid and urgent vectors and returning the winner index plus any_valid. It is reused for both the urgent and normal passes.

Test Plan:
- Reset mid-BUSY: requester 1 accepted, assert rst_in -> next cycle state IDLE, all outputs 0, counters 0; later txn_done_in is ignored.
- Single request: req_valid_in = 2'b10, down_ready_in = 1 -> cycle+1 select_out = 1, grant_valid_out = 1, req_ready_out = 2'b10; cycle+2 busy_out = 1; txn_done_in -> IDLE.
- Simultaneous requests: req_valid_in = 2'b11 -> select_out = 0 granted first; requester 1's counter = 1; after done, requester 1 is granted with select_out = 1.
- Starvation: REQUESTERS = 2, MAX_WAIT = 2, requester 0 re-requests every time and requester 1 holds valid -> requester 0 wins 2 decisions, requester 1 wins the 3rd decision despite requester 0 being valid.
- Backpressure: GRANTED with down_ready_in = 0 for 5 cycles -> req_ready_out = 0, select_out stable, no state change; raise ready -> accept, BUSY.
- Valid drop: in GRANTED, deassert req_valid_in[select_out] with down_ready_in = 0 -> next cycle IDLE, grant_valid_out = 0, no BUSY entry.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory-request arbiter: FSM state encoding,
// default sizing constants and a lowest-set-bit finder used by the picker.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    BUSY    = 2'd2
  } arb_state_e;

  localparam int DEF_REQUESTERS = 2;
  localparam int DEF_MAX_WAIT   = 8;

  // Widest request vector the helper can scan; arb_pick zero-extends into it.
  localparam int MAX_VEC = 32;

  function automatic int lowest_set_idx(input logic [MAX_VEC-1:0] vec);
    int idx;
    idx = 0;
    for (int i = MAX_VEC - 1; i >= 0; i--) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational priority encoder: lowest-index bit set in (valid & mask).
// The top uses one instance for the urgent pass and one for the normal pass.
module arb_pick
  import mem_arb_pkg::*;
#(
  parameter int N = 2,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] valid_i,
  input  logic [N-1:0] mask_i,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  logic [N-1:0]       cand;
  logic [MAX_VEC-1:0] cand_ext;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cand             = valid_i & mask_i;
    cand_ext         = '0;
    cand_ext[N-1:0]  = cand;
    any_o            = |cand;
    idx_o            = W'(lowest_set_idx(cand_ext));
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Fixed-priority request arbiter with starvation promotion; holds the grant
// and select index from acceptance until the downstream signals completion.
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int REQUESTERS = DEF_REQUESTERS,
  parameter  int MAX_WAIT   = DEF_MAX_WAIT,
  localparam int SEL_WIDTH  = $clog2(REQUESTERS)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [REQUESTERS-1:0] req_valid_in,
  output logic [REQUESTERS-1:0] req_ready_out,
  output logic [SEL_WIDTH-1:0]  select_out,
  output logic                  grant_valid_out,
  input  logic                  down_ready_in,
  input  logic                  txn_done_in,
  output logic                  busy_out
);

  localparam int                CNT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_WAIT);

  arb_state_e             state_q, state_d;
  logic [SEL_WIDTH-1:0]   sel_q, sel_d;
  logic [CNT_W-1:0]       cnt_q [REQUESTERS];
  logic [CNT_W-1:0]       cnt_d [REQUESTERS];

  logic [REQUESTERS-1:0]  urgent;
  logic [REQUESTERS-1:0]  all_ones;
  logic [SEL_WIDTH-1:0]   urg_idx, norm_idx, winner;
  logic                   urg_any, norm_any;

  assign all_ones = '1;

  always_comb begin
    urgent = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      urgent[i] = (cnt_q[i] == CNT_MAX);
    end
  end

  arb_pick #(.N(REQUESTERS), .W(SEL_WIDTH)) u_pick_urgent (
    .valid_i (req_valid_in),
    .mask_i  (urgent),
    .idx_o   (urg_idx),
    .any_o   (urg_any)
  );

  arb_pick #(.N(REQUESTERS), .W(SEL_WIDTH)) u_pick_normal (
    .valid_i (req_valid_in),
    .mask_i  (all_ones),
    .idx_o   (norm_idx),
    .any_o   (norm_any)
  );

  assign winner = urg_any ? urg_idx : norm_idx;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (norm_any) begin
          sel_d   = winner;
          state_d = GRANTED;
          // Counters move only here: winner resets, losers age, idle ones clear.
          for (int i = 0; i < REQUESTERS; i++) begin
            if (i == int'(winner))      cnt_d[i] = '0;
            else if (req_valid_in[i])   cnt_d[i] = (cnt_q[i] == CNT_MAX) ? CNT_MAX
                                                                         : cnt_q[i] + CNT_W'(1);
            else                        cnt_d[i] = '0;
          end
        end
      end
      GRANTED: begin
        if (!req_valid_in[sel_q])  state_d = IDLE;
        else if (down_ready_in)    state_d = BUSY;
      end
      BUSY: begin
        if (txn_done_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      sel_q   <= '0;
      // NOTE: the counter array is a handful of flops, not RAM, so it is reset like any register.
      for (int i = 0; i < REQUESTERS; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant_valid_out = (state_q == GRANTED);
  assign busy_out        = (state_q == BUSY);
  assign select_out      = sel_q;

  // Only combinational output: ready follows downstream for the granted slot.
  always_comb begin
    req_ready_out = '0;
    if (state_q == GRANTED) req_ready_out[sel_q] = down_ready_in;
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter (2 requesters, MAX_WAIT=2) with a scoreboard
// of expected grant indices checked by a monitor at every accepted handshake.
module tb_mem_req_arbiter;

  localparam int N  = 2;
  localparam int MW = 2;

  logic         clk_in = 1'b0;
  logic         rst_in;
  logic [N-1:0] req_valid_in;
  logic [N-1:0] req_ready_out;
  logic         select_out;
  logic         grant_valid_out;
  logic         down_ready_in;
  logic         txn_done_in;
  logic         busy_out;

  int errors = 0;
  int checks = 0;
  int exp_q[$];

  mem_req_arbiter #(.REQUESTERS(N), .MAX_WAIT(MW)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .req_valid_in    (req_valid_in),
    .req_ready_out   (req_ready_out),
    .select_out      (select_out),
    .grant_valid_out (grant_valid_out),
    .down_ready_in   (down_ready_in),
    .txn_done_in     (txn_done_in),
    .busy_out        (busy_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_in);
  endtask

  // Monitor: every accepted handshake must match the next expected winner.
  always @(negedge clk_in) begin
    if (!rst_in && grant_valid_out && down_ready_in && req_valid_in[select_out]) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: accepted select %0d with empty queue", select_out);
      end else begin
        int e;
        e = exp_q.pop_front();
        check("sb_select", 32'(select_out), 32'(e));
        check("sb_ready_onehot", 32'(req_ready_out), 32'(1) << e);
      end
    end
  end

  // One full transaction: decision, accept, done, with a bubble check.
  task automatic run_txn(input string tag, input logic [N-1:0] valid, input int exp_sel);
    exp_q.push_back(exp_sel);
    req_valid_in  = valid;
    down_ready_in = 1'b1;
    step();
    sample();
    check({tag, "_grant_valid"}, 32'(grant_valid_out), 32'd1);
    step();
    down_ready_in = 1'b0;
    sample();
    check({tag, "_busy"}, 32'(busy_out), 32'd1);
    check({tag, "_busy_sel"}, 32'(select_out), 32'(exp_sel));
    txn_done_in = 1'b1;
    step();
    txn_done_in = 1'b0;
    sample();
    check({tag, "_bubble"}, 32'(grant_valid_out | busy_out), 32'd0);
    req_valid_in = '0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in        = 1'b1;
    req_valid_in  = '0;
    down_ready_in = 1'b0;
    txn_done_in   = 1'b0;
    step();
    step();
    rst_in = 1'b0;
    sample();
    check("rst_select", 32'(select_out), 32'd0);
    check("rst_grant_valid", 32'(grant_valid_out), 32'd0);
    check("rst_busy", 32'(busy_out), 32'd0);
    check("rst_ready", 32'(req_ready_out), 32'd0);

    // Single request from requester 1.
    exp_q.push_back(1);
    req_valid_in  = 2'b10;
    down_ready_in = 1'b1;
    step();
    sample();
    check("single_grant_valid", 32'(grant_valid_out), 32'd1);
    check("single_select", 32'(select_out), 32'd1);
    check("single_ready", 32'(req_ready_out), 32'b10);
    step();
    req_valid_in  = '0;
    down_ready_in = 1'b0;
    sample();
    check("single_busy", 32'(busy_out), 32'd1);
    check("single_busy_ready", 32'(req_ready_out), 32'd0);
    check("single_busy_gv", 32'(grant_valid_out), 32'd0);
    txn_done_in = 1'b1;
    step();
    txn_done_in = 1'b0;
    sample();
    check("single_idle", 32'(busy_out | grant_valid_out), 32'd0);

    // Simultaneous requests: 0 first, then 1 after 0 withdraws.
    run_txn("simul_a", 2'b11, 0);
    run_txn("simul_b", 2'b10, 1);

    // Starvation: requester 1 is promoted on the third decision.
    run_txn("starve_1", 2'b11, 0);
    run_txn("starve_2", 2'b11, 0);
    run_txn("starve_3", 2'b11, 1);
    run_txn("starve_4", 2'b11, 0);

    // Backpressure: grant held with ready low for 5 cycles.
    exp_q.push_back(0);
    req_valid_in  = 2'b01;
    down_ready_in = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      sample();
      check("bp_ready_low", 32'(req_ready_out), 32'd0);
      check("bp_select", 32'(select_out), 32'd0);
      check("bp_grant_valid", 32'(grant_valid_out), 32'd1);
      step();
    end
    down_ready_in = 1'b1;
    sample();
    check("bp_ready_up", 32'(req_ready_out), 32'b01);
    step();
    down_ready_in = 1'b0;
    req_valid_in  = '0;
    sample();
    check("bp_busy", 32'(busy_out), 32'd1);
    txn_done_in = 1'b1;
    step();
    txn_done_in = 1'b0;

    // Valid drop while granted: back to IDLE with no BUSY entry.
    req_valid_in = 2'b10;
    step();
    sample();
    check("drop_granted_sel", 32'(select_out), 32'd1);
    req_valid_in = '0;
    step();
    sample();
    check("drop_grant_valid", 32'(grant_valid_out), 32'd0);
    check("drop_busy", 32'(busy_out), 32'd0);
    check("drop_sel_held", 32'(select_out), 32'd1);
    step();
    sample();
    check("drop_no_busy", 32'(busy_out), 32'd0);

    // Reset mid-BUSY with requester 1 accepted.
    exp_q.push_back(1);
    req_valid_in  = 2'b10;
    down_ready_in = 1'b1;
    step();
    step();
    req_valid_in  = '0;
    down_ready_in = 1'b0;
    sample();
    check("rb_busy_pre", 32'(busy_out), 32'd1);
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    sample();
    check("rb_select", 32'(select_out), 32'd0);
    check("rb_grant_valid", 32'(grant_valid_out), 32'd0);
    check("rb_busy", 32'(busy_out), 32'd0);
    check("rb_ready", 32'(req_ready_out), 32'd0);
    txn_done_in = 1'b1;
    step();
    txn_done_in = 1'b0;
    sample();
    check("rb_done_ignored", 32'(busy_out | grant_valid_out), 32'd0);

    // Counters restart from zero after reset.
    run_txn("post_rst_1", 2'b11, 0);
    run_txn("post_rst_2", 2'b11, 0);
    run_txn("post_rst_3", 2'b11, 1);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
